// File: rtl/tpcd_pattern_gen.sv
// Dartboard stimulus generator: a 16-beat score stream, a 2-cycle gap, then N dart beats from a Fibonacci LFSR.
// Optional TPCD_GEN_RESP_WAIT_EN adds a bounded wait for the downstream result before signalling done.
module tpcd_pattern_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic [3:0]  num_darts,
   input  logic        out_valid,
   input  logic [6:0]  out_sum,
   output logic        in_valid_1,
   output logic [2:0]  in_score,
   output logic        in_valid_2,
   output logic [3:0]  in_dart,
   output logic [2:0]  in_rotation,
   output logic        rotate_flag,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [6:0]  result
);

   localparam logic [2:0]  ST_IDLE  = 3'd0;
   localparam logic [2:0]  ST_SCORE = 3'd1;
   localparam logic [2:0]  ST_GAP   = 3'd2;
   localparam logic [2:0]  ST_DART  = 3'd3;
   localparam logic [2:0]  ST_WAIT  = 3'd4;
   localparam logic [2:0]  ST_FIN   = 3'd5;

   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
   localparam logic [3:0]  SCORE_LAST   = 4'd15;
   localparam logic [3:0]  GAP_LAST     = 4'd1;

   logic [2:0]  state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] lfsr_step;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  darts_q, darts_d;
   logic        timeout_q, timeout_d;
   logic [6:0]  result_q, result_d;

   logic        in_valid_1_q, in_valid_1_d;
   logic [2:0]  in_score_q, in_score_d;
   logic        in_valid_2_q, in_valid_2_d;
   logic [3:0]  in_dart_q, in_dart_d;
   logic [2:0]  in_rotation_q, in_rotation_d;
   logic        rotate_flag_q, rotate_flag_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

`ifdef TPCD_GEN_RESP_WAIT_EN
   localparam logic [7:0]  WAIT_LAST = 8'd254;
   logic [7:0]  wait_q, wait_d;
`else
   logic        unused_resp;
   assign unused_resp = ^{out_valid, out_sum};
`endif

   assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      cnt_d     = cnt_q;
      darts_d   = darts_q;
      timeout_d = timeout_q;
      result_d  = result_q;
`ifdef TPCD_GEN_RESP_WAIT_EN
      wait_d    = wait_q;
`endif
      // Every SCORE/DART cycle is a valid beat, so the LFSR steps exactly once per beat.
      if ((state_q == ST_SCORE) || (state_q == ST_DART)) begin
         lfsr_d = lfsr_step;
      end
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SCORE;
               lfsr_d    = (seed == 16'd0) ? LFSR_DEFAULT : seed;
               darts_d   = (num_darts == 4'd0) ? 4'd1 : num_darts;
               cnt_d     = 4'd0;
               timeout_d = 1'b0;
               result_d  = 7'd0;
            end
         end
         ST_SCORE: begin
            if (cnt_q == SCORE_LAST) begin
               state_d = ST_GAP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_DART;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DART: begin
            if (cnt_q == (darts_q - 4'd1)) begin
               cnt_d = 4'd0;
`ifdef TPCD_GEN_RESP_WAIT_EN
               state_d = ST_WAIT;
               wait_d  = 8'd0;
`else
               state_d = ST_FIN;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_WAIT: begin
`ifdef TPCD_GEN_RESP_WAIT_EN
            // A response on the final wait cycle wins over the timeout.
            if (out_valid) begin
               result_d  = out_sum;
               timeout_d = 1'b0;
               state_d   = ST_FIN;
            end else if (wait_q == WAIT_LAST) begin
               result_d  = 7'd0;
               timeout_d = 1'b1;
               state_d   = ST_FIN;
            end else begin
               wait_d = wait_q + 8'd1;
            end
`else
            state_d = ST_FIN;
`endif
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so each beat carries the LFSR value it is issued with.
   always_comb begin
      in_valid_1_d  = (state_d == ST_SCORE);
      in_valid_2_d  = (state_d == ST_DART);
      in_score_d    = in_valid_1_d ? lfsr_d[2:0] : 3'd0;
      in_dart_d     = in_valid_2_d ? lfsr_d[3:0] : 4'd0;
      in_rotation_d = in_valid_2_d ? lfsr_d[6:4] : 3'd0;
      rotate_flag_d = in_valid_2_d ? lfsr_d[7]   : 1'b0;
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= 16'd0;
         cnt_q     <= 4'd0;
         darts_q   <= 4'd0;
         timeout_q <= 1'b0;
         result_q  <= 7'd0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         cnt_q     <= cnt_d;
         darts_q   <= darts_d;
         timeout_q <= timeout_d;
         result_q  <= result_d;
      end
   end

`ifdef TPCD_GEN_RESP_WAIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= 8'd0;
      end else begin
         wait_q <= wait_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_valid_1_q  <= 1'b0;
         in_score_q    <= 3'd0;
         in_valid_2_q  <= 1'b0;
         in_dart_q     <= 4'd0;
         in_rotation_q <= 3'd0;
         rotate_flag_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         in_valid_1_q  <= in_valid_1_d;
         in_score_q    <= in_score_d;
         in_valid_2_q  <= in_valid_2_d;
         in_dart_q     <= in_dart_d;
         in_rotation_q <= in_rotation_d;
         rotate_flag_q <= rotate_flag_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign in_valid_1  = in_valid_1_q;
   assign in_score    = in_score_q;
   assign in_valid_2  = in_valid_2_q;
   assign in_dart     = in_dart_q;
   assign in_rotation = in_rotation_q;
   assign rotate_flag = rotate_flag_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign result      = result_q;

endmodule
